axil_uart_tx_slave: RTL and testbench

- AXI-lite responder for the UART window at the top 4 KiB of the address space (addresses 0xFFFFFFFFFFFFF000 and above).
- Terminates the UART-side read and write channels coming out of the memory controller.
- Provides a memory-mapped transmit FIFO and status register.
- Serialises queued bytes onto an 8N1 UART TX line at a fixed baud divider.

---
 rtl/axil_uart_tx_slave_if.sv | 40 ++++
 rtl/axil_uart_tx_slave.sv | 250 +++++++++++++++++++++++++
 tb/tb_axil_uart_tx_slave.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_uart_tx_slave_if.sv
// AXI-lite read/write channel bundle shared by the memory controller and its
// peripheral windows; slave modports are used by responders such as the UART.
interface axil_interface_if;
   logic [63:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [63:0] rdata;
   logic        rvalid;
   logic        rready;

   logic [63:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   modport rd_slv (
      input  araddr, arvalid, rready,
      output arready, rdata, rvalid
   );

   modport rd_mst (
      output araddr, arvalid, rready,
      input  arready, rdata, rvalid
   );

   modport wr_slv (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bvalid
   );

   modport wr_mst (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bvalid
   );
endinterface

// File: rtl/axil_uart_tx_slave.sv
// AXI-lite UART transmit window: TXDATA/STATUS registers, a byte FIFO and an
// 8N1 serialiser running at a fixed number of clocks per bit.
module axil_uart_tx_slave #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   axil_interface_if.rd_slv       read,
   axil_interface_if.wr_slv       write,
   output logic                   uart_tx
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [8:0] OFF_TXDATA = 9'd0;
   localparam logic [8:0] OFF_STATUS = 9'd1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } tx_state_e;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid and its payload hold until that edge, and ready may depend
   // combinationally on valid (AW and W are only ever accepted as a pair).

   // ---------------------------------------------------------------- signals
   logic              rvalid_q;
   logic [63:0]       rdata_q;
   logic              bvalid_q;
   logic              ar_hs;
   logic              wr_accept;
   logic [8:0]        rd_off;
   logic [8:0]        wr_off;
   logic [63:0]       rd_word;
   logic [63:0]       status_word;

   logic [7:0]        mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push_req;
   logic              push_ok;
   logic              push_drop;
   logic              fifo_pop;
   logic              ovf_clr;
   logic              overflow;

   tx_state_e         state;
   tx_state_e         state_nx;
   logic [BW-1:0]     baud_cnt;
   logic [BW-1:0]     baud_nx;
   logic              baud_last;
   logic [2:0]        bit_idx;
   logic [2:0]        bit_nx;
   logic [7:0]        shift;
   logic [7:0]        shift_nx;
   logic              tx_nx;
   logic              tx_busy;

   logic              unused_bits;

   assign unused_bits = ^{read.araddr[63:12], read.araddr[2:0],
                          write.awaddr[63:12], write.awaddr[2:0],
                          write.wdata[63:8], write.wstrb[7:1]};

   // ----------------------------------------------------------- read channel
   assign read.arready = !rst && !rvalid_q;
   assign read.rvalid  = rvalid_q;
   assign read.rdata   = rdata_q;
   assign ar_hs        = read.arvalid && read.arready;
   assign rd_off       = read.araddr[11:3];

   always_comb begin
      status_word       = '0;
      status_word[0]    = fifo_full;
      status_word[1]    = fifo_empty;
      status_word[2]    = tx_busy;
      status_word[3]    = overflow;
      status_word[15:8] = 8'(fifo_count);
   end

   always_comb begin
      rd_word = '0;
      if (rd_off == OFF_STATUS) begin
         rd_word = status_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_word;
      end else if (rvalid_q && read.rready) begin
         rvalid_q <= 1'b0;
      end
   end

   // ---------------------------------------------------------- write channel
   assign wr_accept     = !rst && !bvalid_q && write.awvalid && write.wvalid;
   assign write.awready = wr_accept;
   assign write.wready  = wr_accept;
   assign write.bvalid  = bvalid_q;
   assign wr_off        = write.awaddr[11:3];

   assign push_req  = wr_accept && (wr_off == OFF_TXDATA) && write.wstrb[0];
   assign ovf_clr   = wr_accept && (wr_off == OFF_STATUS) && write.wstrb[0]
                      && write.wdata[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         bvalid_q <= 1'b0;
      end else if (wr_accept) begin
         bvalid_q <= 1'b1;
      end else if (bvalid_q && write.bready) begin
         bvalid_q <= 1'b0;
      end
   end

   // ------------------------------------------------------------------- FIFO
   assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
   assign fifo_empty = (fifo_count == '0);
   // Fullness is judged before this cycle's pop, so a push racing a pop on a
   // full FIFO is still dropped.
   assign push_ok    = push_req && !fifo_full;
   assign push_drop  = push_req && fifo_full;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= write.wdata[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push_ok, fifo_pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (push_drop) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- TX FSM
   assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
   assign tx_busy   = (state != S_IDLE);

   always_comb begin
      state_nx = state;
      baud_nx  = baud_cnt;
      bit_nx   = bit_idx;
      shift_nx = shift;
      fifo_pop = 1'b0;
      tx_nx    = 1'b1;

      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_nx = mem[rd_ptr];
               baud_nx  = '0;
               state_nx = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_nx  = '0;
               bit_nx   = 3'd0;
               state_nx = S_DATA;
            end else begin
               baud_nx = baud_cnt + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_nx = '0;
               if (bit_idx == 3'd7) begin
                  state_nx = S_STOP;
               end else begin
                  bit_nx = bit_idx + 3'd1;
               end
            end else begin
               baud_nx = baud_cnt + BW'(1);
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_nx  = '0;
               state_nx = S_IDLE;
            end else begin
               baud_nx = baud_cnt + BW'(1);
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      // The line level is derived from the next state so the register lines up
      // with the state: low on the very first START cycle.
      case (state_nx)
         S_START: tx_nx = 1'b0;
         S_DATA:  tx_nx = shift_nx[bit_nx];
         default: tx_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         shift    <= 8'd0;
         uart_tx  <= 1'b1;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_nx;
         bit_idx  <= bit_nx;
         shift    <= shift_nx;
         uart_tx  <= tx_nx;
      end
   end

endmodule

// File: tb/tb_axil_uart_tx_slave.sv
// Directed bench for axil_uart_tx_slave with read-data and UART-byte
// scoreboards fed by the stimulus and drained by independent monitors.
module tb_axil_uart_tx_slave;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam logic [63:0] A_TX = 64'hFFFF_FFFF_FFFF_F000;
   localparam logic [63:0] A_ST = 64'hFFFF_FFFF_FFFF_F008;

   // ------------------------------------------------------- clock and reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_tx;
   always #5 clk = ~clk;

   axil_interface_if bus ();

   axil_uart_tx_slave #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .read    (bus),
      .write   (bus),
      .uart_tx (uart_tx)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] rd_exp_q[$];
   logic [7:0]  uart_exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      check(name, 64'(act), 64'(req));
   endtask

   // --------------------------------------------------------------- monitors
   always @(negedge clk) begin
      if (!rst && bus.rvalid && bus.rready) begin
         if (rd_exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rd_unexpected: actual 0x%0h required no response", bus.rdata);
         end else begin
            check("rdata", bus.rdata, rd_exp_q.pop_front());
         end
      end
   end

   logic       mon_active = 1'b0;
   int         mon_t = 0;
   logic [7:0] mon_byte = 8'd0;
   logic       prev_tx = 1'b1;

   always @(negedge clk) begin
      if (rst) begin
         mon_active <= 1'b0;
      end else if (!mon_active) begin
         if (prev_tx === 1'b1 && uart_tx === 1'b0) begin
            mon_active <= 1'b1;
            mon_t      <= 1;
         end
      end else begin
         mon_t <= mon_t + 1;
         if (mon_t == 2) chk1("uart_start_bit", uart_tx, 1'b0);
         if (mon_t >= 6 && mon_t <= 34 && ((mon_t - 6) % 4) == 0)
            mon_byte[(mon_t - 6) / 4] <= uart_tx;
         if (mon_t == 38) begin
            chk1("uart_stop_bit", uart_tx, 1'b1);
            mon_active <= 1'b0;
            if (uart_exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL uart_unexpected: actual frame 0x%0h required none", mon_byte);
            end else begin
               check("uart_byte", 64'(mon_byte), 64'(uart_exp_q.pop_front()));
            end
         end
      end
      prev_tx <= rst ? 1'b1 : uart_tx;
   end

   // ----------------------------------------------------------- driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [63:0] addr, input logic [63:0] req);
      bit hs;
      hs = 1'b0;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      rd_exp_q.push_back(req);
      for (int i = 0; i < 50 && !hs; i++) begin
         @(negedge clk);
         hs = bus.arready;
         step();
      end
      bus.arvalid = 1'b0;
      if (!hs) begin
         n_checks++;
         $display("FAIL ar_timeout: actual no arready required handshake for 0x%0h", addr);
         void'(rd_exp_q.pop_back());
      end else begin
         chk1("rvalid_after_ar", bus.rvalid, 1'b1);
      end
   endtask

   task automatic wr_present(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
   endtask

   task automatic wr_complete();
      bit hs;
      hs = 1'b0;
      for (int i = 0; i < 50 && !hs; i++) begin
         @(negedge clk);
         chk1("awready_eq_wready", bus.awready, bus.wready);
         hs = bus.awready && bus.wready;
         step();
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (!hs) begin
         n_checks++;
         $display("FAIL aw_w_timeout: actual no handshake required handshake for 0x%0h", bus.awaddr);
      end else begin
         chk1("bvalid_after_w", bus.bvalid, 1'b1);
      end
   endtask

   task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
      wr_present(addr, data, strb);
      wr_complete();
   endtask

   task automatic wait_rd_drain(input int budget);
      for (int i = 0; i < budget && rd_exp_q.size() != 0; i++) step();
      check("rd_drain", 64'(rd_exp_q.size()), 64'd0);
      rd_exp_q.delete();
   endtask

   task automatic wait_uart_drain(input int budget);
      for (int i = 0; i < budget && (uart_exp_q.size() != 0 || mon_active); i++) step();
      check("uart_drain", 64'(uart_exp_q.size()), 64'd0);
      uart_exp_q.delete();
   endtask

   // --------------------------------------------------------------- stimulus
   logic [9:0] frame;
   logic [7:0] burst [6];
   int         low_cycles;

   initial begin
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b1;
      bus.awaddr  = '0;
      bus.awvalid = 1'b1;
      bus.wdata   = '0;
      bus.wstrb   = 8'h01;
      bus.wvalid  = 1'b1;
      bus.bready  = 1'b1;
      burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      // Reset: nothing may be accepted even with AW/W presented
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst_arready", bus.arready, 1'b0);
      chk1("rst_awready", bus.awready, 1'b0);
      chk1("rst_wready", bus.wready, 1'b0);
      chk1("rst_uart_tx", uart_tx, 1'b1);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk1("post_rst_uart_tx", uart_tx, 1'b1);
      chk1("post_rst_rvalid", bus.rvalid, 1'b0);
      chk1("post_rst_bvalid", bus.bvalid, 1'b0);
      step();

      // Decode: status, txdata, unused offset, ignored low/high address bits
      do_read(A_ST, 64'h02);
      do_read(A_TX, 64'h00);
      do_read(64'hFFFF_FFFF_FFFF_F010, 64'h00);
      do_read(64'hFFFF_FFFF_FFFF_F00C, 64'h02);
      do_read(64'h0000_0000_0000_0008, 64'h02);
      wait_rd_drain(20);
      do_write(A_TX, 64'h77, 8'h02);
      do_read(A_ST, 64'h02);
      wait_rd_drain(20);

      // Single frame of 0xA5, checked cycle by cycle
      uart_exp_q.push_back(8'hA5);
      do_write(A_TX, 64'hA5, 8'h01);
      frame = {1'b1, 8'hA5, 1'b0};
      @(negedge clk);
      chk1("tx_before_start", uart_tx, 1'b1);
      for (int c = 0; c < 10 * CPB; c++) begin
         @(negedge clk);
         chk1("tx_frame_level", uart_tx, frame[c / CPB]);
      end
      @(negedge clk);
      chk1("tx_idle_after_frame", uart_tx, 1'b1);
      step();
      wait_uart_drain(20);

      // Read held off by rready=0
      bus.rready = 1'b0;
      do_read(A_ST, 64'h02);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk1("hold_rvalid", bus.rvalid, 1'b1);
         check("hold_rdata", bus.rdata, 64'h02);
         chk1("hold_arready", bus.arready, 1'b0);
         step();
      end
      bus.rready = 1'b1;
      @(negedge clk);
      step();
      chk1("rvalid_cleared", bus.rvalid, 1'b0);

      // W ahead of AW, then a second write blocked by bready=0
      bus.bready  = 1'b0;
      bus.wdata   = 64'hDEAD;
      bus.wstrb   = 8'hFF;
      bus.wvalid  = 1'b1;
      bus.awvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("w_only_awready", bus.awready, 1'b0);
         chk1("w_only_wready", bus.wready, 1'b0);
         step();
      end
      bus.awaddr  = 64'hFFFF_FFFF_FFFF_F018;
      bus.awvalid = 1'b1;
      wr_complete();
      wr_present(64'hFFFF_FFFF_FFFF_F010, 64'h01, 8'h01);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("blocked_awready", bus.awready, 1'b0);
         chk1("blocked_bvalid", bus.bvalid, 1'b1);
         step();
      end
      bus.bready = 1'b1;
      wr_complete();
      do_read(A_ST, 64'h02);
      wait_rd_drain(20);

      // Burst into a running frame: fill, overflow, then clear
      for (int i = 0; i < 6; i++) begin
         if (i < 5) uart_exp_q.push_back(burst[i]);
         do_write(A_TX, 64'(burst[i]), 8'h01);
      end
      do_read(A_ST, 64'h40D);
      do_write(A_ST, 64'hF7, 8'h01);
      do_write(A_ST, 64'h08, 8'hFE);
      do_read(A_ST, 64'h40D);
      do_write(A_ST, 64'h08, 8'h01);
      do_read(A_ST, 64'h405);
      wait_rd_drain(20);
      wait_uart_drain(400);
      repeat (5) step();
      do_read(A_ST, 64'h02);
      wait_rd_drain(20);

      // Reset 13 cycles into a frame with bytes queued and a read pending
      do_write(A_TX, 64'hC3, 8'h01);
      do_write(A_TX, 64'h5A, 8'h01);
      do_write(A_TX, 64'h6B, 8'h01);
      bus.rready = 1'b0;
      do_read(A_ST, 64'h204);
      repeat (8) step();
      rst = 1'b1;
      @(negedge clk);
      chk1("tx_mid_frame", uart_tx, 1'b0);
      step();
      chk1("abort_uart_tx", uart_tx, 1'b1);
      chk1("abort_rvalid", bus.rvalid, 1'b0);
      chk1("abort_bvalid", bus.bvalid, 1'b0);
      chk1("abort_arready", bus.arready, 1'b0);
      rd_exp_q.delete();
      uart_exp_q.delete();
      bus.rready = 1'b1;
      step();
      rst = 1'b0;
      do_read(A_ST, 64'h02);
      wait_rd_drain(20);
      low_cycles = 0;
      repeat (60) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) low_cycles++;
      end
      check("no_start_after_rst", 64'(low_cycles), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
